// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the riscv32i core and the data-memory port.
//
// One request at a time is taken from the core. Misaligned requests are answered
// with an error and never reach memory. Aligned requests run a req/gnt/rvalid
// handshake that gives up after TIMEOUT cycles in REQ+WAIT. Load data is lane-shifted
// and then sign- or zero-extended before it is returned.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready        core request handshake (ready only while idle)
//   req_we, req_addr           store flag, byte address
//   req_wdata                  right-aligned store data
//   lb, lh, lbu, lhu           size / unsigned flags from the decoder (word when lb=lh=0)
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err         extended load data, error flag (misaligned or timeout)
//   stall                      request in flight
//   mem_req/mem_gnt            memory request, held until granted
//   mem_we, mem_addr           write flag, word-aligned address
//   mem_wdata, mem_be          lane-replicated store data, byte enables
//   mem_rvalid, mem_rdata      load data return
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        lb,
    input  logic        lh,
    input  logic        lbu,
    input  logic        lhu,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // The counter runs 0..TIMEOUT-1 across REQ+WAIT, so the last allowed cycle is TIMEOUT-1.
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 32'd1);
    localparam logic [TW-1:0] CNT_ONE  = TW'(32'd1);

    state_t        state_r;
    logic [TW-1:0] cnt_r;
    logic [1:0]    off_r;
    logic          byte_r;
    logic          half_r;
    logic          uns_r;
    logic [31:0]   res_data_r;
    logic          res_err_r;

    logic          misaligned_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic [31:0]   load_s;
    logic          timeout_s;

    // Shift the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic        is_byte,
        input logic        is_half,
        input logic        is_uns
    );
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        if (is_byte) begin
            extract_load = is_uns ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        end else if (is_half) begin
            extract_load = is_uns ? {16'h0000, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        end else begin
            // Word accesses are always aligned, so the lane is the whole word.
            extract_load = lane;
        end
    endfunction

    // Decode the incoming request: alignment check, byte enables and replicated store data.
    always_comb begin
        be_s         = 4'hF;
        wdata_s      = req_wdata;
        misaligned_s = 1'b0;
        if (lb) begin
            be_s         = 4'b0001 << req_addr[1:0];
            wdata_s      = {4{req_wdata[7:0]}};
            misaligned_s = 1'b0;
        end else if (lh) begin
            be_s         = 4'b0011 << req_addr[1:0];
            wdata_s      = {2{req_wdata[15:0]}};
            misaligned_s = req_addr[0];
        end else begin
            be_s         = 4'hF;
            wdata_s      = req_wdata;
            misaligned_s = (req_addr[1:0] != 2'b00);
        end
    end

    assign load_s    = extract_load(mem_rdata, off_r, byte_r, half_r, uns_r);
    assign timeout_s = (cnt_r == CNT_LAST);

    // Sequencer state, captured request, timeout counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= {TW{1'b0}};
            off_r      <= 2'b00;
            byte_r     <= 1'b0;
            half_r     <= 1'b0;
            uns_r      <= 1'b0;
            res_data_r <= 32'h0000_0000;
            res_err_r  <= 1'b0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            rsp_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            mem_be     <= 4'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        stall      <= 1'b1;
                        off_r      <= req_addr[1:0];
                        byte_r     <= lb;
                        half_r     <= lh & ~lb;
                        uns_r      <= lbu | lhu;
                        mem_we     <= req_we;
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        mem_be     <= be_s;
                        mem_wdata  <= wdata_s;
                        cnt_r      <= {TW{1'b0}};
                        res_data_r <= 32'h0000_0000;
                        if (misaligned_s) begin
                            // Answered locally; memory never sees this access.
                            res_err_r <= 1'b1;
                            state_r   <= S_RESP;
                        end else begin
                            res_err_r <= 1'b0;
                            mem_req   <= 1'b1;
                            state_r   <= S_REQ;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state_r <= S_RESP;
                        end else if (mem_rvalid) begin
                            res_data_r <= load_s;
                            state_r    <= S_RESP;
                        end else if (timeout_s) begin
                            res_err_r <= 1'b1;
                            state_r   <= S_RESP;
                        end else begin
                            cnt_r   <= cnt_r + CNT_ONE;
                            state_r <= S_WAIT;
                        end
                    end else if (timeout_s) begin
                        mem_req   <= 1'b0;
                        res_err_r <= 1'b1;
                        state_r   <= S_RESP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    // Data arriving on the timeout cycle still counts as a completion.
                    if (mem_rvalid) begin
                        res_data_r <= load_s;
                        state_r    <= S_RESP;
                    end else if (timeout_s) begin
                        res_err_r <= 1'b1;
                        state_r   <= S_RESP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= S_WAIT;
                    end
                end
                S_RESP: begin
                    // The pulse lands together with ready, so the core may issue its next request at once.
                    rsp_valid <= 1'b1;
                    rsp_rdata <= res_data_r;
                    rsp_err   <= res_err_r;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    mem_req   <= 1'b0;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl. A behavioural model derives every expected
// value (alignment, enables, store data, extended load data, latency, error) from
// the access rules with plain arithmetic; the bench plays the memory side.
module tb_lsu_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        lb, lh, lbu, lhu;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // Observations recorded by run_txn
    int          obs_latency;
    int          obs_req_cycles;
    logic        obs_accepted;
    logic        obs_stable;
    logic        obs_ready_busy;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    logic        obs_we;

    lsu_ctrl #(.TIMEOUT(T), .TW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .lb(lb), .lh(lh), .lbu(lbu), .lhu(lhu),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic model_mis(input logic [31:0] addr, input int sz);
        if (sz == 2) return (addr % 32'd2) != 32'd0;
        if (sz == 4) return (addr % 32'd4) != 32'd0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input int sz);
        int o;
        o = int'(addr % 32'd4);
        if (sz == 1) return 4'(1 << o);
        if (sz == 2) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] w, input int sz);
        if (sz == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input int sz, input logic uns);
        logic [31:0] v;
        v = word >> (8 * int'(addr % 32'd4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // Index (0-based, from the first REQ cycle) of the completing cycle.
    function automatic int model_done(input logic we, input int g, input int r);
        return we ? g : g + r;
    endfunction

    function automatic int model_latency(input logic mis, input logic we, input int g, input int r);
        if (mis) return 2;
        if (model_done(we, g, r) < T) return model_done(we, g, r) + 3;
        return T + 2;
    endfunction

    function automatic int model_req_cycles(input logic mis, input int g);
        if (mis) return 0;
        return (g + 1 < T) ? g + 1 : T;
    endfunction

    // ---------------- memory-side driver ----------------
    // Issues one request and plays memory: gnt on REQ cycle g, rvalid r cycles later.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int sz, input logic uns, input logic [31:0] rdata,
                           input int g, input int r);
        bit first;
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        lb = (sz == 1); lh = (sz == 2); lbu = (sz == 1) && uns; lhu = (sz == 2) && uns;
        mem_rdata = rdata;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        obs_accepted = (req_ready === 1'b1);
        obs_latency = -1; obs_req_cycles = 0; obs_stable = 1'b1; obs_ready_busy = 1'b0;
        obs_rdata = 32'h0; obs_err = 1'b0; obs_be = 4'h0; obs_wdata = 32'h0;
        obs_addr = 32'h0; obs_we = 1'b0;
        first = 1'b1;
        for (int n = 1; n <= 40 && obs_latency < 0; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_req === 1'b1) begin
                obs_req_cycles++;
                if (first) begin
                    obs_be = mem_be; obs_wdata = mem_wdata; obs_addr = mem_addr; obs_we = mem_we;
                    first = 1'b0;
                end else if (mem_be !== obs_be || mem_wdata !== obs_wdata ||
                             mem_addr !== obs_addr || mem_we !== obs_we) begin
                    obs_stable = 1'b0;
                end
            end
            if (rsp_valid === 1'b1) begin
                obs_latency = n; obs_rdata = rsp_rdata; obs_err = rsp_err;
            end else if (req_ready !== 1'b0 || stall !== 1'b1) begin
                obs_ready_busy = 1'b1;
            end
            mem_gnt    = (n - 1 == g);
            mem_rvalid = !we && (n - 1 == g + r);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        lb = 1'b0; lh = 1'b0; lbu = 1'b0; lhu = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if ({req_ready, stall, rsp_valid, rsp_err, mem_req, mem_we} !== 6'b100000) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", {req_ready, stall, rsp_valid, rsp_err, mem_req, mem_we}, 6'b100000); end
        checks++; if ({mem_addr, mem_wdata, rsp_rdata, mem_be} !== 100'h0) begin errors++; $display("FAIL reset_data: got %h %h %h %h expected all zero", mem_addr, mem_wdata, rsp_rdata, mem_be); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({req_ready, stall, mem_req} !== 3'b100) begin errors++; $display("FAIL reset_release: got %b expected %b", {req_ready, stall, mem_req}, 3'b100); end
    endtask

    task automatic test_store_byte();
        run_txn(1'b1, 32'h103, 32'hAB, 1, 1'b0, 32'h0, 1, 0);
        checks++; if (mem_be !== 4'b1000 || obs_be !== 4'b1000) begin errors++; $display("FAIL st_be: got %b expected %b", obs_be, 4'b1000); end
        checks++; if (obs_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL st_wdata: got %h expected %h", obs_wdata, 32'hABAB_ABAB); end
        checks++; if (obs_addr !== 32'h100 || obs_we !== 1'b1) begin errors++; $display("FAIL st_addr: got %h/%b expected %h/1", obs_addr, obs_we, 32'h100); end
        checks++; if (obs_latency !== 4 || obs_err !== 1'b0) begin errors++; $display("FAIL st_rsp: got lat=%0d err=%b expected lat=4 err=0", obs_latency, obs_err); end
        checks++; if (obs_req_cycles !== 2 || obs_stable !== 1'b1) begin errors++; $display("FAIL st_req: got cycles=%0d stable=%b expected 2/1", obs_req_cycles, obs_stable); end
    endtask

    task automatic test_load_half();
        run_txn(1'b0, 32'h22, 32'h0, 2, 1'b0, 32'h8001_0000, 0, 0);
        checks++; if (obs_rdata !== 32'hFFFF_8001 || obs_err !== 1'b0) begin errors++; $display("FAIL lh_data: got %h expected %h", obs_rdata, 32'hFFFF_8001); end
        checks++; if (obs_latency !== 3 || obs_be !== 4'b1100 || obs_addr !== 32'h20) begin errors++; $display("FAIL lh_timing: got lat=%0d be=%b addr=%h expected 3/1100/20", obs_latency, obs_be, obs_addr); end
        run_txn(1'b0, 32'h22, 32'h0, 2, 1'b1, 32'h8001_0000, 0, 0);
        checks++; if (obs_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h expected %h", obs_rdata, 32'h0000_8001); end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 32'h41, 32'h0, 4, 1'b0, 32'h1234_5678, 0, 0);
        checks++; if (obs_latency !== 2 || obs_err !== 1'b1) begin errors++; $display("FAIL mis_word: got lat=%0d err=%b expected 2/1", obs_latency, obs_err); end
        checks++; if (obs_req_cycles !== 0 || obs_rdata !== 32'h0) begin errors++; $display("FAIL mis_word_req: got req=%0d data=%h expected 0/0", obs_req_cycles, obs_rdata); end
        run_txn(1'b1, 32'h23, 32'h5555, 2, 1'b0, 32'h0, 0, 0);
        checks++; if (obs_latency !== 2 || obs_err !== 1'b1 || obs_req_cycles !== 0) begin errors++; $display("FAIL mis_half: got lat=%0d err=%b req=%0d expected 2/1/0", obs_latency, obs_err, obs_req_cycles); end
    endtask

    task automatic test_timeout();
        logic seen;
        run_txn(1'b0, 32'h80, 32'h0, 4, 1'b0, 32'hCAFE_F00D, 0, 20);
        checks++; if (obs_latency !== T + 2 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin errors++; $display("FAIL to_load: got lat=%0d err=%b data=%h expected %0d/1/0", obs_latency, obs_err, obs_rdata, T + 2); end
        checks++; if (obs_req_cycles !== 1) begin errors++; $display("FAIL to_load_req: got %0d expected 1", obs_req_cycles); end
        seen = 1'b0;
        mem_rvalid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || stall !== 1'b0) seen = 1'b1;
        end
        mem_rvalid = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL to_late_rvalid: got %b expected %b", seen, 1'b0); end
        run_txn(1'b1, 32'h84, 32'h1, 4, 1'b0, 32'h0, 20, 0);
        checks++; if (obs_latency !== T + 2 || obs_err !== 1'b1 || obs_req_cycles !== T) begin errors++; $display("FAIL to_store: got lat=%0d err=%b req=%0d expected %0d/1/%0d", obs_latency, obs_err, obs_req_cycles, T + 2, T); end
        run_txn(1'b0, 32'h88, 32'h0, 4, 1'b0, 32'h1357_9BDF, 1, 2);
        checks++; if (obs_latency !== T + 2 || obs_err !== 1'b0 || obs_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL to_edge_win: got lat=%0d err=%b data=%h expected %0d/0/13579bdf", obs_latency, obs_err, obs_rdata, T + 2); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        lb = 1'b0; lh = 1'b0; lbu = 1'b0; lhu = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mr_wait: got stall=%b req=%b expected 1/0", stall, mem_req); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({req_ready, stall, mem_req, rsp_valid, rsp_err, mem_we} !== 6'b100000 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin errors++; $display("FAIL mr_reset: got %b addr=%h be=%b expected 100000/0/0", {req_ready, stall, mem_req, rsp_valid, rsp_err, mem_we}, mem_addr, mem_be); end
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mr_stale_rvalid: got %b expected %b", seen, 1'b0); end
        run_txn(1'b0, 32'h3, 32'h0, 1, 1'b0, 32'h9A00_0000, 1, 1);
        checks++; if (obs_rdata !== 32'hFFFF_FF9A || obs_err !== 1'b0 || obs_latency !== 5 || obs_be !== 4'b1000) begin errors++; $display("FAIL mr_new_lb: got data=%h err=%b lat=%0d be=%b expected ffffff9a/0/5/1000", obs_rdata, obs_err, obs_latency, obs_be); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [3];
        int acc_cyc [3];
        int acc_cnt, rsp_cnt;
        logic bad_ready;
        acc_cnt = 0; rsp_cnt = 0; bad_ready = 1'b0;
        for (int i = 0; i < 3; i++) data[i] = $urandom;
        lb = 1'b0; lh = 1'b0; lbu = 1'b0; lhu = 1'b0; req_we = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (req_ready === stall) bad_ready = 1'b1;
            if (rsp_valid === 1'b1) begin
                checks++; if (rsp_cnt >= 3 || rsp_rdata !== data[rsp_cnt % 3] || cyc - acc_cyc[rsp_cnt % 3] !== 3) begin errors++; $display("FAIL b2b_rsp%0d: got %h at +%0d expected %h at +3", rsp_cnt, rsp_rdata, cyc - acc_cyc[rsp_cnt % 3], data[rsp_cnt % 3]); end
                rsp_cnt++;
            end
            mem_gnt = mem_req; mem_rvalid = mem_req;
            mem_rdata = data[(acc_cnt + 2) % 3];
            if (acc_cnt < 3) begin
                req_valid = 1'b1; req_addr = 32'h200 + 32'(acc_cnt * 4);
            end else begin
                req_valid = 1'b0;
            end
            if (req_ready === 1'b1 && acc_cnt < 3) begin
                acc_cyc[acc_cnt] = cyc;
                acc_cnt++;
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
        checks++; if (acc_cnt !== 3 || rsp_cnt !== 3) begin errors++; $display("FAIL b2b_count: got acc=%0d rsp=%0d expected 3/3", acc_cnt, rsp_cnt); end
        checks++; if (bad_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_idle: got %b expected %b", bad_ready, 1'b0); end
    endtask

    task automatic test_random();
        logic we, uns, mis;
        logic [31:0] addr, wdata, rdata, exp_data;
        int sz, g, r, d;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: sz = 1;
                1: sz = 2;
                default: sz = 4;
            endcase
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'(sz - 1);
            g = $urandom_range(0, 5); r = $urandom_range(0, 3);
            mis = model_mis(addr, sz);
            d = model_done(we, g, r);
            exp_data = (mis || we || d >= T) ? 32'h0 : model_load(rdata, addr, sz, uns);
            run_txn(we, addr, wdata, sz, uns, rdata, g, r);
            checks++; if (obs_accepted !== 1'b1 || obs_latency !== model_latency(mis, we, g, r)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, obs_latency, model_latency(mis, we, g, r)); end
            checks++; if (obs_err !== (mis || d >= T)) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", i, obs_err, (mis || d >= T)); end
            checks++; if (obs_rdata !== exp_data) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, obs_rdata, exp_data); end
            checks++; if (obs_req_cycles !== model_req_cycles(mis, g) || obs_ready_busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_req: got cycles=%0d busy=%b expected %0d/0", i, obs_req_cycles, obs_ready_busy, model_req_cycles(mis, g)); end
            if (!mis) begin
                checks++; if (obs_be !== model_be(addr, sz) || obs_wdata !== model_wdata(wdata, sz) || obs_addr !== (addr & 32'hFFFF_FFFC) || obs_we !== we || obs_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_mem: got be=%b wd=%h a=%h we=%b st=%b expected be=%b wd=%h a=%h we=%b", i, obs_be, obs_wdata, obs_addr, obs_we, obs_stable, model_be(addr, sz), model_wdata(wdata, sz), addr & 32'hFFFF_FFFC, we); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
